// File: rtl/sw_debounce.sv
// sw_debounce: synchronizes and debounces switch pins, producing a clean vector plus rise/fall/changed pulses.
// Sticky per-bit edge flags (sw_edge/edge_clr) are built only when SW_DEBOUNCE_EDGE_LATCH_EN is defined.
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] sw_edge
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] accept;

    always_comb begin
        sync_d[0] = sw_raw;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Any cycle matching the clean value restarts the count; acceptance also restarts it.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync_last[i] != clean_q[i]) && (cnt_q[i] == CNT_MAX);
            cnt_d[i]  = (sync_last[i] == clean_q[i] || accept[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        clean_d   = clean_q ^ accept;
        rise_d    = accept & sync_last;
        fall_d    = accept & ~sync_last;
        changed_d = |accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    assign changed  = changed_q;

`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_q, edge_d;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_comb edge_d = (edge_q & ~edge_clr) | accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_q <= '0;
        else          edge_q <= edge_d;
    end

    assign sw_edge = edge_q;
`else
    logic unused_edge_clr;
    assign unused_edge_clr = ^edge_clr;
    assign sw_edge = '0;
`endif
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronizes and debounces the raw DE10 slide-switch inputs before they reach the switch PIO's `in_port`. Each bit passes through a flip-flop synchronizer chain, then a per-bit stability counter. The clean, glitch-free vector and per-bit edge pulses are then presented to the Qsys system. It sits between the FPGA switch pins and the PIO, in the `clk` domain of the Qsys system.

## Interface

Parameters:
- `WIDTH`, default 10: number of switch bits.
- `SYNC_STAGES`, default 2: synchronizer depth; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable `clk` cycles required to accept a change (10 ms at 50 MHz); must be ≥ 1.

Ports:
- `clk` in, 1: system clock.
- `reset_n` in, 1: reset, asynchronous, active-low. Clock is `clk`.
- `sw_raw` in, WIDTH: asynchronous switch pins.
- `sw_clean` out, WIDTH: debounced switch state; drives the PIO `in_port`.
- `sw_rise` out, WIDTH: one-cycle pulse per bit on an accepted 0→1 change.
- `sw_fall` out, WIDTH: one-cycle pulse per bit on an accepted 1→0 change.
- `changed` out, 1: one-cycle pulse; the OR of `sw_rise | sw_fall`.
- `edge_clr` in, WIDTH: per-bit clear for `sw_edge`.
- `sw_edge` out, WIDTH: sticky edge flags (see Configuration).

## Operation

- **Synchronizer.** Each bit of `sw_raw` shifts through `SYNC_STAGES` registers. `sync[i]` is the last stage.
- **Counter.** Each bit has an independent counter, `cnt[i]`, of width `$clog2(DEBOUNCE_CYCLES)` (minimum 1 bit).
- **Per-bit rule, evaluated every `clk` edge:**
  - `sync[i] == sw_clean[i]`: `cnt[i] <= 0`.
  - `sync[i] != sw_clean[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `sync[i] != sw_clean[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_clean[i] <= sync[i]`, `cnt[i] <= 0`, and pulse `sw_rise[i]` or `sw_fall[i]` according to the new value.
- **Bounce handling.** Any single cycle with `sync` equal to `sw_clean` restarts that bit's count from 0. Partial counts are never retained.
- **Independence.** Bits are fully independent. Multiple bits may update in the same cycle. `changed` is asserted once for that cycle.
- **Pulses.** `sw_rise`, `sw_fall` and `changed` are registered outputs. They are high only in the cycle where `sw_clean` takes its new value.
- **Reset.** All synchronizer stages, `cnt`, `sw_clean`, `sw_rise`, `sw_fall`, `changed` and `sw_edge` reset to 0.
  - A switch that is high during reset is reported as a rising edge after the normal latency.
  - Reset asserted mid-count discards the count.

## Timing

- **Latency.** A raw change that is stable from before edge 1 appears on `sw_clean` after edge `SYNC_STAGES + DEBOUNCE_CYCLES`. The rise/fall/`changed` pulse appears on the same edge.
- **`DEBOUNCE_CYCLES = 1`.** `sw_clean` follows `sync` one cycle later. Any difference is accepted immediately.
- **Minimum spacing.** Two accepted changes on the same bit are at least `DEBOUNCE_CYCLES` cycles apart.
- **Glitch rejection.** A raw pulse shorter than `DEBOUNCE_CYCLES` cycles, measured at `sync`, produces no output change.
- **Counter range.** The counter never wraps; its maximum value is `DEBOUNCE_CYCLES-1`.

## Configuration

- Macro: `SW_DEBOUNCE_EDGE_LATCH_EN`.
- **Defined:**
  - `sw_edge[i]` is set on any `sw_rise[i]` or `sw_fall[i]` pulse.
  - `sw_edge[i]` is cleared by `edge_clr[i]` on the next edge.
  - If set and clear occur in the same cycle, set wins.
  - `sw_edge[i]` holds until cleared.
- **Not defined:**
  - `sw_edge` is constant 0.
  - `edge_clr` is ignored.
  - No sticky registers are synthesized.
  - All other behaviour is identical.

## Test plan

All directed scenarios use `WIDTH=10`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.

- **Clean step.** `sw_raw` goes 0x000→0x001 and holds → `sw_clean=0x001` exactly 6 edges later; `sw_rise=0x001` and `changed=1` for one cycle; `sw_fall=0`.
- **Bounce.** Bit 3 toggles 1,0,1,0 each cycle, then holds 1 → no output during bouncing; `sw_clean[3]=1` 6 edges after the final hold begins.
- **Short glitch.** Bit 5 is high for 3 cycles, then low → `sw_clean` stays 0x000; no pulses.
- **Simultaneous change.** `sw_raw` 0x000→0x3FF, then after settling 0x3FF→0x2AA → first `sw_rise=0x3FF`, `changed` one pulse; then `sw_fall=0x155`, `sw_clean=0x2AA`.
- **Reset mid-count.** Bit 0 is raised; `reset_n` is pulsed low 4 edges later → all outputs 0 immediately; after release, `sw_clean[0]=1` 6 edges later.
- **Edge latch (macro defined).** A rise on bit 2 → `sw_edge=0x004` until `edge_clr=0x004`. With `edge_clr[2]` held high during a new fall → `sw_edge[2]` stays 1.
- **Edge latch (macro undefined).** Same stimulus → `sw_edge=0`.
